pipe_hazard_ctrl: RTL

//  Issue controller for the 4-stage pipeline (fetch, decode/regread, execute, writeback/mem).
//  It holds a per-register scoreboard of in-flight writes and decides each cycle whether
//  the decode-stage instruction may issue. It sequences branch flushes when stage 3

---
 rtl/pipe_hazard_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: issue controller for the 4-stage pipeline.
// Tracks in-flight register writes, sequences branch flushes, gates the
// multi-cycle float unit and latches halt when sys retires.
module pipe_hazard_ctrl #(
  parameter int NREG      = 16,
  parameter int RW        = 4,
  parameter int FLUSH_CYC = 2,
  parameter int MC_LAT    = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            dec_valid,
  input  logic [RW-1:0]   dec_dst,
  input  logic            dec_dst_wr,
  input  logic [RW-1:0]   dec_src_a,
  input  logic            dec_src_a_en,
  input  logic [RW-1:0]   dec_src_b,
  input  logic            dec_src_b_en,
  input  logic            dec_multi,
  input  logic            wb_valid,
  input  logic [RW-1:0]   wb_reg,
  input  logic            redirect,
  input  logic            halt_req,
  output logic            issue,
  output logic            stall,
  output logic            flush,
  output logic            mc_busy,
  output logic            halted,
  output logic [NREG-1:0] busy_mask
);

  // The top register index is the PC; it is never tracked in the scoreboard.
  localparam logic [RW-1:0] PC_IDX = RW'(NREG - 1);
  localparam int FC_W = $clog2(FLUSH_CYC + 1);
  localparam int MC_W = $clog2(MC_LAT) + 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [FC_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [MC_W-1:0] mc_cnt_q, mc_cnt_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic            hz_src_a, hz_src_b, hz_dst, hz_mc, hazard;

  // A register hazard exists only for an enabled, non-PC index whose write is pending.
  function automatic logic reg_pending(input logic [NREG-1:0] mask,
                                       input logic [RW-1:0]   idx,
                                       input logic            en);
    reg_pending = en && (idx != PC_IDX) && mask[idx];
  endfunction

  // One-hot decode of a register index into a scoreboard-wide mask.
  function automatic logic [NREG-1:0] reg_bit(input logic [RW-1:0] idx);
    reg_bit = NREG'(1) << idx;
  endfunction

  // Hazard detection and issue decision for the decode-stage instruction.
  always_comb begin
    hz_src_a = reg_pending(busy_q, dec_src_a, dec_src_a_en);
    hz_src_b = reg_pending(busy_q, dec_src_b, dec_src_b_en);
    hz_dst   = reg_pending(busy_q, dec_dst, dec_dst_wr);
    hz_mc    = dec_multi && mc_busy;
    hazard   = hz_src_a || hz_src_b || hz_dst || hz_mc;
    issue    = dec_valid && !hazard && (state_q == ST_RUN) && !flush
               && !redirect && !halt_req;
    stall    = dec_valid && !issue;
  end

  // Control FSM next state: flush sequencing and sticky halt (halt beats redirect).
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (halt_req) begin
          state_d = ST_HALT;
        end else if (redirect) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = FC_W'(FLUSH_CYC);
        end
      end
      ST_FLUSH: begin
        if (halt_req) begin
          state_d     = ST_HALT;
          flush_cnt_d = '0;
        end else if (redirect) begin
          flush_cnt_d = FC_W'(FLUSH_CYC);
        end else if (flush_cnt_q <= FC_W'(1)) begin
          state_d     = ST_RUN;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q - FC_W'(1);
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d     = ST_RUN;
        flush_cnt_d = '0;
      end
    endcase
  end

  // Scoreboard next state: redirect squashes everything, otherwise set beats clear.
  always_comb begin
    busy_d = busy_q;
    if (redirect) begin
      busy_d = '0;
    end else begin
      if (wb_valid) begin
        busy_d = busy_d & ~reg_bit(wb_reg);
      end
      if (issue && dec_dst_wr && (dec_dst != PC_IDX)) begin
        busy_d = busy_d | reg_bit(dec_dst);
      end
    end
  end

  // Float unit occupancy countdown; a redirect squashes the in-flight op.
  always_comb begin
    mc_cnt_d = mc_cnt_q;
    if (redirect) begin
      mc_cnt_d = '0;
    end else if (issue && dec_multi) begin
      mc_cnt_d = MC_W'(MC_LAT - 1);
    end else if (mc_cnt_q != '0) begin
      mc_cnt_d = mc_cnt_q - MC_W'(1);
    end
  end

  // State registers, all cleared by the asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= '0;
      mc_cnt_q    <= '0;
      busy_q      <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      mc_cnt_q    <= mc_cnt_d;
      busy_q      <= busy_d;
    end
  end

  // Status outputs decoded directly from registered state.
  always_comb begin
    flush     = (state_q == ST_FLUSH);
    halted    = (state_q == ST_HALT);
    mc_busy   = (mc_cnt_q != '0);
    busy_mask = busy_q;
  end

endmodule
